// File: rtl/uart_serial_core.sv
// Serial side of the UART path: 8N1 transmitter with a one-byte holding register and a
// centre-sampling receiver, both fed by edge-detected strobes from the bus bridge.
module uart_serial_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_bus,
    input  logic       rst,
    input  logic [7:0] host_data_i,
    input  logic       host_wrn,
    input  logic       host_rdn,
    output logic [7:0] host_data_o,
    output logic       tready,
    output logic       tsre,
    output logic       data_ready,
    output logic       overrun,
    output logic       framing_err,
    output logic       uart_txd,
    input  logic       uart_rxd
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic wrn_prev;
    logic rdn_prev;
    logic wr_event;
    logic rd_event;

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            wrn_prev <= 1'b1;
            rdn_prev <= 1'b1;
        end else begin
            wrn_prev <= host_wrn;
            rdn_prev <= host_rdn;
        end
    end

    assign wr_event = wrn_prev & ~host_wrn;
    assign rd_event = rdn_prev & ~host_rdn;

    // ---------------------------------------------------------------- transmitter
    tx_state_t       tx_state;
    tx_state_t       tx_next;
    logic            hold_full;
    logic [7:0]      hold_reg;
    logic [7:0]      tx_shift;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic            tx_bit_end;
    logic            tx_load;

    assign tx_bit_end = (tx_cnt == DIV_LAST);
    assign tready     = ~hold_full;

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // tx_load marks the cycle the shifter takes the holding byte, from IDLE or chained after STOP
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (hold_full) begin
                    tx_next = TX_START;
                    tx_load = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end && (tx_bit == 3'd7)) begin
                    tx_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (hold_full) begin
                        tx_next = TX_START;
                        tx_load = 1'b1;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        tsre     = (tx_state == TX_IDLE) && !hold_full;
        case (tx_state)
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = tx_shift[0];
            default:  uart_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_reg  <= 8'h00;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end else if (wr_event && !hold_full) begin
            hold_reg  <= host_data_i;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            tx_shift <= 8'h00;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
        end else if (tx_load) begin
            tx_shift <= hold_reg;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- receiver
    rx_state_t       rx_state;
    rx_state_t       rx_next;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic            rx_fall;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick;
    logic            byte_done;
    logic            frame_bad;

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // A start needs a real high-to-low edge, so a line stuck low after a bad stop bit is ignored
    assign rx_fall = rx_prev & ~rx_sync;
    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick && (rx_bit == 3'd7)) begin
                    rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if ((rx_state == RX_STOP) && rx_tick) begin
            byte_done = rx_sync;
            frame_bad = ~rx_sync;
        end
    end

    // While idle the counter sits at the half-bit value, ready for the start-bit centre
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt <= HALF_LAST;
            rx_bit <= 3'd0;
        end else if (rx_tick) begin
            rx_cnt <= DIV_LAST;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // A completing byte beats a simultaneous read; the read still clears any overrun
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            host_data_o <= 8'h00;
            data_ready  <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            if (byte_done) begin
                host_data_o <= rx_shift;
                data_ready  <= 1'b1;
                if (rd_event) begin
                    overrun <= 1'b0;
                end else if (data_ready) begin
                    overrun <= 1'b1;
                end
            end else if (rd_event) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_serial_core.md
Name: uart_serial_core

Overview:
- Serial side of the UART path, directly downstream of the bus-to-UART bridge.
- Consumes the bridge's strobes: byte, active-low write strobe, active-low read strobe.
- Produces the bridge's inputs: received byte, tready, tsre.
- Contains an 8N1 transmitter (holding register plus shift register) and a centre-sampling receiver driving the board TXD/RXD pins.

Parameters:
CLK_FREQ, 50000000, clk_bus frequency in Hz
BAUD, 115200, serial bit rate; DIV = CLK_FREQ/BAUD (integer, truncated), cycles per bit; DIV >= 4 required

Ports:
clk_bus  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
host_data_i  in  8  byte to transmit (bridge write data)
host_wrn  in  1  active-low write strobe from bridge
host_rdn  in  1  active-low read strobe from bridge
host_data_o  out  8  last received byte
tready  out  1  1 = TX holding register empty
tsre  out  1  1 = transmitter fully idle (holding and shifter empty)
data_ready  out  1  1 = unread received byte in host_data_o
overrun  out  1  sticky: byte received while data_ready=1
framing_err  out  1  one-cycle pulse: bad stop bit
uart_txd  out  1  serial output, idle high
uart_rxd  in  1  serial input, asynchronous

Behaviour:
- Reset is asynchronous and active-high. Asserting rst forces, immediately and mid-frame included:
  - uart_txd=1, tready=1, tsre=1
  - data_ready=0, overrun=0, framing_err=0, host_data_o=8'h00
  - both FSMs to IDLE
- Strobe detection:
  - host_wrn and host_rdn are registered once (prev value, reset to 1).
  - A write event is host_wrn=0 and prev=1. The read event is defined the same way on host_rdn.
  - A strobe held low for several cycles counts as one event.
- TX holding register:
  - On a write event with tready=1: capture host_data_i; tready=0 from the next cycle.
  - On a write event with tready=0: the byte is dropped, no state change.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with holding full: move byte to shifter; tready=1 and txd=0 (START) on the following cycle.
  - Path from a write event with the shifter idle:
    - write event at edge k
    - tready low at cycle k+1
    - start bit begins at k+2
    - tready high again at k+2
  - Each bit lasts exactly DIV cycles. Order: start(0), d0..d7 LSB first, stop(1).
  - At the end of STOP:
    - holding full: load it and enter START with no idle gap.
    - otherwise: IDLE.
  - tsre = (TX FSM in IDLE) and tready. It falls in the cycle after the write event and rises the cycle after the last stop-bit cycle.
- RX synchroniser: uart_rxd passes through 2 flops, reset value 1. All RX logic uses the synced value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: on a synced 1→0 transition; counter loaded for DIV/2 cycles.
  - START centre sample:
    - 0: go to DATA.
    - 1: glitch, return to IDLE, no flags.
  - DATA: sample every DIV cycles, 8 samples, shifted LSB first.
  - STOP: sample after DIV cycles.
    - 1: host_data_o ← byte and data_ready=1, same edge.
    - 0: byte discarded, framing_err=1 for one cycle.
  - After the STOP sample: return to IDLE. A new start requires the synced line to have been seen high first.
- Read side:
  - A read event clears data_ready and overrun on the next edge. host_data_o holds its value.
  - Byte completes while data_ready=1: host_data_o is overwritten; overrun=1, sticky.
  - Byte completion and read event in the same cycle: new byte wins; data_ready stays 1; overrun not set by that byte and cleared by the read.
- TX and RX are fully independent. A loopback of txd to rxd must work.

Test Plan:
(all with CLK_FREQ=1600, BAUD=100 → DIV=16)
1. Reset, then write 8'hA5 with host_wrn low 3 cycles → exactly one frame; txd low 16 cycles; then bits 1,0,1,0,0,1,0,1 at 16 cycles each; then stop high. tready low for one cycle only; tsre low for 161 cycles total.
2. Two writes (8'h55, then 8'h0F while first frame busy) → frames back-to-back with no idle gap. A third write while tready=0 → dropped; only 2 frames appear.
3. Loopback txd→rxd, send 8'h3C → data_ready=1 with host_data_o=8'h3C. Read strobe → data_ready=0 next cycle; host_data_o still 8'h3C.
4. Drive rxd low for 5 cycles only → no data_ready, no framing_err. Drive a frame 8'h81 with stop bit 0 → framing_err single-cycle pulse; data_ready stays 0.
5. Receive 8'h11 then 8'h22 without reading → host_data_o=8'h22, overrun=1. Read → overrun=0, data_ready=0.
6. Assert rst mid-data-bit of a TX frame → txd=1, tready=1, tsre=1 immediately. After release, a new write transmits a clean frame.
